// File: rtl/logic_ops_pkg.sv
// logic_ops_pkg: opcode constants and output-stage state encoding for the shared logic unit
package logic_ops_pkg;
  localparam logic [1:0] LOGIC_AND = 2'b00;
  localparam logic [1:0] LOGIC_OR  = 2'b01;
  localparam logic [1:0] LOGIC_XOR = 2'b10;
  localparam logic [1:0] LOGIC_NOR = 2'b11;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/logic_op_unit.sv
// logic_op_unit: combinational bitwise AND/OR/XOR/NOR of two operands
module logic_op_unit
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_comb y = op == LOGIC_AND ? (a & b) : op == LOGIC_OR ? (a | b) : op == LOGIC_XOR ? (a ^ b) : ~(a | b);
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin shared logic unit with one result register; LOGIC_ARB_ZERO_FLAG_EN adds resp_zero
module logic_unit_arbiter
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data
`ifdef LOGIC_ARB_ZERO_FLAG_EN
  ,
  output logic             resp_zero
`endif
);
  state_t           state;
  logic             rr_ptr;
  logic             can_accept;
  logic             grant0;
  logic             grant1;
  logic             xfer;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  always_comb begin
    can_accept = state == EMPTY || resp_ready;
    grant0     = req0_valid && (!req1_valid || !rr_ptr);
    grant1     = req1_valid && (!req0_valid || rr_ptr);
    req0_ready = grant0 && can_accept && !reset;
    req1_ready = grant1 && can_accept && !reset;
    xfer       = req0_ready || req1_ready;
    op         = grant1 ? req1_op : req0_op;
    a          = grant1 ? req1_a : req0_a;
    b          = grant1 ? req1_b : req0_b;
    resp_valid = state == FULL;
  end
  logic_op_unit #(.WIDTH(WIDTH)) u_op (
    .op(op),
    .a (a),
    .b (b),
    .y (y)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      rr_ptr    <= 1'b0;
      resp_id   <= 1'b0;
      resp_data <= '0;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
      resp_zero <= 1'b0;
`endif
    end else if (xfer) begin
      state     <= FULL;
      rr_ptr    <= ~grant1;
      resp_id   <= grant1;
      resp_data <= y;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
      resp_zero <= y == '0;
`endif
    end else if (resp_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one bitwise logic unit (AND/OR/XOR/NOR) between two requesters (e.g. main ALU path and a branch/compare helper) with valid/ready handshakes.
- Round-robin arbitration, one registered result stage, downstream backpressure.
- Sits in the ALU logic part, in front of the result mux.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 handshake accepted this cycle.
- req0_op  input  2  requester 0 opcode.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: as requester 0, for requester 1.
- resp_valid  output  1  result register holds a valid result.
- resp_ready  input  1  consumer takes the result this cycle.
- resp_id  output  1  requester index that produced resp_data.
- resp_data  output  WIDTH  registered result.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Opcodes are bitwise, per bit:
  - 2'b00 AND (a & b)
  - 2'b01 OR (a | b)
  - 2'b10 XOR (a ^ b)
  - 2'b11 NOR ~(a | b)
  - No logical-reduction semantics.
- Reset values: resp_valid=0, resp_id=0, resp_data=0, rr_ptr=0 (requester 0 favoured). req*_ready=0 while reset is high.
- Output stage FSM has two states:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
  - can_accept = EMPTY or (FULL and resp_ready).
- Grant, combinational:
  - Only one requester valid: it is granted.
  - Both valid: the requester equal to rr_ptr is granted.
  - reqN_ready = grantN & can_accept. At most one ready is high per cycle.
- Handshake: a transfer occurs when reqN_valid & reqN_ready. Requesters hold valid, op, a and b stable until ready. Ready may be deasserted by the block at any time.
- On transfer at edge t:
  - resp_data <= op(a,b), resp_id <= N, state -> FULL.
  - rr_ptr <= ~N.
  - Latency is exactly 1 cycle; the result is visible after edge t.
- FULL & resp_ready & no new transfer -> EMPTY. resp_data and resp_id keep their stale value.
- FULL & resp_ready & new transfer in the same cycle -> stays FULL with the new result. Full throughput is 1 op/cycle.
- FULL & !resp_ready: no transfer, and resp_valid, resp_id and resp_data are held bit-stable.
- rr_ptr updates only on transfer. An idle cycle does not change fairness.
- With both requesters continuously valid and resp_ready=1, grants alternate strictly 0,1,0,1.
- Reset asserted mid-operation: any pending result is discarded and the block returns to the reset values next edge. No partial transfer completes on a cycle where reset=1.
- Opcode X/illegal encodings do not exist, since all 4 codes are defined.

Optional Feature:
- Macro LOGIC_ARB_ZERO_FLAG_EN.
- Defined:
  - Adds output port resp_zero (1 bit), registered alongside resp_data.
  - resp_zero = 1 when the result is all zeros. Reset value is 0.
  - It is held under backpressure exactly like resp_data.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Shared package/header logic_ops_pkg:
  - opcode constants LOGIC_AND=2'b00, LOGIC_OR=2'b01, LOGIC_XOR=2'b10, LOGIC_NOR=2'b11.
  - FSM state encodings EMPTY=1'b0, FULL=1'b1.
- One sub-module, logic_op_unit: combinational (op, a, b) -> result at WIDTH. It is instantiated once, after the grant mux.

Test Plan:
- Reset then single op: req0 AND a=32'hF0F0_F0F0, b=32'hFF00_FF00, resp_ready=1 -> req0_ready=1 in cycle 0; cycle 1 resp_valid=1, resp_id=0, resp_data=32'hF000_F000.
- All opcodes: a=32'h0000_FFFF, b=32'h00FF_00FF -> OR=32'h00FF_FFFF, XOR=32'h00FF_FF00, NOR=32'hFF00_0000, AND=32'h0000_00FF.
- Contention: both valid for 4 cycles, resp_ready=1 -> resp_id sequence 0,1,0,1. A single requester idle for some cycles does not skip its turn.
- Backpressure: result pending with resp_ready=0 for 3 cycles -> resp_* stable and both ready=0. Raise resp_ready with req1 valid -> drain and new accept happen in the same cycle, with no bubble.
- Reset mid-stream: assert reset while FULL with resp_ready=0 -> next cycle resp_valid=0, resp_data=0, rr_ptr=0.
- With LOGIC_ARB_ZERO_FLAG_EN: XOR a=b=32'hDEAD_BEEF -> resp_zero=1. OR a=0, b=1 -> resp_zero=0.
